// File: rtl/fifo_wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb_pkg
// Shared types and constants for the round-robin FIFO write arbiter.
//   arb_state_t : arbiter FSM encoding (ARB_IDLE, ARB_BURST)
//   STAT_W      : width of each statistics counter
//   sat_inc     : saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package fifo_wr_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   localparam int STAT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      logic [STAT_W-1:0] r;
      if (v == {STAT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + STAT_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb_if
// Bundles the requester streams and the FIFO write port around the arbiter.
//   req_valid/req_data/req_ready : NUM_REQ valid/ready streams (packed data)
//   fifo_full/fifo_wr_en/fifo_data_in : shared FIFO write port
//   grant_valid/grant_id : current grant status
//   stat_words/stat_stall : statistics, only with FIFO_WR_ARB_STATS_EN
// Modports: master = arbiter side, slave = requesters + FIFO side.
// ---------------------------------------------------------------------------
interface fifo_wr_arb_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   import fifo_wr_arb_pkg::*;

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic                          grant_valid;
   logic [ID_W-1:0]               grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [NUM_REQ*STAT_W-1:0]     stat_words;
   logic [STAT_W-1:0]             stat_stall;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id,
             stat_words, stat_stall
   );
   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id,
             stat_words, stat_stall
   );
`else
   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
   );
   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
   );
`endif

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first set bit of req_i scanning
// ptr_i, ptr_i+1, ... with wrap modulo N (N need not be a power of two).
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < N)
//   found_o : any request set
//   idx_o   : selected index (0 when nothing found)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic          found_o,
   output logic [PW-1:0] idx_o
);

   // Scan from ptr_i upward with explicit wrap; first hit wins.
   always_comb begin
      int j;
      found_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) begin
            j = j - N;
         end else begin
            j = j;
         end
         if (!found_o && req_i[j]) begin
            found_o = 1'b1;
            idx_o   = PW'(j);
         end else begin
            found_o = found_o;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant lasts up to MAX_BURST words; the served requester then drops to the
// lowest priority. Re-arbitration costs one IDLE cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (also blocks writes in its cycle)
//   bus : fifo_wr_arb_if.master (requester streams, FIFO port, grant status)
// Optional: define FIFO_WR_ARB_STATS_EN to add saturating per-requester word
// counters (stat_words) and a stall-cycle counter (stat_stall).
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic          clk,
   input  logic          rst,
   fifo_wr_arb_if.master bus
);
   import fifo_wr_arb_pkg::*;

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

   arb_state_t            state_q;
   logic [ID_W-1:0]       grant_id_q;
   logic [ID_W-1:0]       rr_ptr_q;
   logic [CNT_W-1:0]      burst_cnt_q;

   logic                  pick_found_s;
   logic [ID_W-1:0]       pick_idx_s;
   logic                  sel_valid_s;
   logic [DATA_WIDTH-1:0] sel_data_s;
   logic                  in_burst_s;
   logic                  xfer_s;
   logic                  stall_s;
   logic [ID_W-1:0]       next_ptr_s;
   logic [NUM_REQ-1:0]    ready_s;
   logic [DATA_WIDTH-1:0] data_out_s;

   rr_pick #(.N(NUM_REQ), .PW(ID_W)) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found_s),
      .idx_o   (pick_idx_s)
   );

   // Mux out the granted requester's valid and data.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_data_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_W'(i)) begin
            sel_valid_s = bus.req_valid[i];
            sel_data_s  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            sel_valid_s = sel_valid_s;
         end
      end
   end

   // Transfer/stall decode; rst gates the write in the same cycle.
   always_comb begin
      in_burst_s = (state_q == ARB_BURST);
      xfer_s     = in_burst_s && sel_valid_s && !bus.fifo_full && !rst;
      stall_s    = in_burst_s && sel_valid_s && bus.fifo_full;
      next_ptr_s = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
      data_out_s = (in_burst_s && !rst) ? sel_data_s : '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ready_s[i] = xfer_s && (grant_id_q == ID_W'(i));
      end
   end

   assign bus.req_ready    = ready_s;
   assign bus.fifo_wr_en   = xfer_s;
   assign bus.fifo_data_in = data_out_s;
   assign bus.grant_valid  = in_burst_s;
   assign bus.grant_id     = grant_id_q;

   // Arbitration FSM: grant, burst counting, release and pointer rotation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found_s) begin
                  grant_id_q  <= pick_idx_s;
                  burst_cnt_q <= '0;
                  state_q     <= ARB_BURST;
               end else begin
                  state_q     <= ARB_IDLE;
               end
            end
            ARB_BURST: begin
               if (!sel_valid_s) begin
                  // Voluntary release: no word moves this cycle.
                  state_q  <= ARB_IDLE;
                  rr_ptr_q <= next_ptr_s;
               end else if (!bus.fifo_full) begin
                  burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                  if (burst_cnt_q == LAST_CNT) begin
                     state_q  <= ARB_IDLE;
                     rr_ptr_q <= next_ptr_s;
                  end else begin
                     state_q  <= ARB_BURST;
                  end
               end else begin
                  // FIFO full: hold grant and count, never a release.
                  state_q <= ARB_BURST;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [NUM_REQ*STAT_W-1:0] words_q;
   logic [STAT_W-1:0]         stall_cnt_q;

   // Saturating per-requester word counters and stall-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         words_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (ready_s[i]) begin
               words_q[i*STAT_W +: STAT_W] <= sat_inc(words_q[i*STAT_W +: STAT_W]);
            end else begin
               words_q[i*STAT_W +: STAT_W] <= words_q[i*STAT_W +: STAT_W];
            end
         end
         if (stall_s) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
      end
   end

   assign bus.stat_words = words_q;
   assign bus.stat_stall = stall_cnt_q;
`endif

endmodule
